// File: rtl/pcap_dma_buf_ctrl_if.sv
// Host/DMA-side signal bundle for the PCAP DMA buffer controller.
// master = host/capture side driving requests, slave = the controller.
interface pcap_dma_buf_ctrl_if #(
  parameter int ADDR_DEPTH = 32,
  parameter int AW         = 32,
  parameter int CNT_W      = 16
);
  localparam int LW = $clog2(ADDR_DEPTH + 1);

  logic             addr_wr_i;
  logic [AW-1:0]    addr_i;
  logic             addr_flush_i;
  logic             arm_i;
  logic             disarm_i;
  logic             end_of_capture_i;
  logic [CNT_W-1:0] blocksize_i;
  logic             data_valid_i;
  logic             irq_ack_i;
  logic [AW-1:0]    dma_addr_o;
  logic             dma_active_o;
  logic [LW-1:0]    queue_level_o;
  logic             irq_o;
  logic [AW-1:0]    irq_addr_o;
  logic [CNT_W-1:0] irq_count_o;
  logic [7:0]       irq_flags_o;

  modport master (
    output addr_wr_i, addr_i, addr_flush_i, arm_i, disarm_i, end_of_capture_i,
           blocksize_i, data_valid_i, irq_ack_i,
    input  dma_addr_o, dma_active_o, queue_level_o, irq_o, irq_addr_o,
           irq_count_o, irq_flags_o
  );

  modport slave (
    input  addr_wr_i, addr_i, addr_flush_i, arm_i, disarm_i, end_of_capture_i,
           blocksize_i, data_valid_i, irq_ack_i,
    output dma_addr_o, dma_active_o, queue_level_o, irq_o, irq_addr_o,
           irq_count_o, irq_flags_o
  );
endinterface

// File: rtl/pcap_dma_buf_ctrl.sv
// PCAP DMA buffer controller: host-filled address queue, per-buffer word
// counting with handover on block full, and a held IRQ status record.
module pcap_dma_buf_ctrl #(
  parameter int ADDR_DEPTH = 32,
  parameter int AW         = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  pcap_dma_buf_ctrl_if.slave bus
);
  localparam int LW = $clog2(ADDR_DEPTH + 1);
  localparam int PW = $clog2(ADDR_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_n;
  logic [AW-1:0]    mem [ADDR_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, wr_base;
  logic [LW-1:0]    level;
  logic [AW-1:0]    dma_addr, dma_addr_n;
  logic [CNT_W-1:0] cnt, cnt_n, blk, blk_n, eff_bs, cnt_inc;
  logic             ovf;
  logic             irq;
  logic [AW-1:0]    irq_addr;
  logic [CNT_W-1:0] irq_count;
  logic [7:0]       irq_flags;

  logic             flush_now, empty, full, pop, push_ok, drop, full_hit;
  logic             comp;
  logic [AW-1:0]    comp_addr;
  logic [CNT_W-1:0] comp_cnt;
  logic [7:0]       comp_flags;

  // Flush only acts in IDLE; a flushing cycle sees the queue as empty so a
  // coincident arm reports an underrun instead of popping a stale entry.
  assign flush_now = bus.addr_flush_i && (state == IDLE);
  assign empty     = (level == '0) || flush_now;
  assign full      = (level == LW'(ADDR_DEPTH)) && !flush_now;
  assign eff_bs    = (blk == '0) ? CNT_W'(1) : blk;
  assign cnt_inc   = cnt + CNT_W'(bus.data_valid_i);
  assign full_hit  = bus.data_valid_i &&
                     (({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, eff_bs});
  assign wr_base   = flush_now ? '0 : wr_ptr;

  // Next-state, pop and completion-record decode.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    blk_n      = blk;
    dma_addr_n = dma_addr;
    pop        = 1'b0;
    comp       = 1'b0;
    comp_addr  = dma_addr;
    comp_cnt   = cnt;
    comp_flags = '0;
    case (state)
      IDLE: begin
        if (bus.arm_i) begin
          if (!empty) begin
            pop        = 1'b1;
            dma_addr_n = mem[rd_ptr];
            blk_n      = bus.blocksize_i;
            cnt_n      = '0;
            state_n    = ACTIVE;
          end else begin
            comp          = 1'b1;
            comp_flags[3] = 1'b1;
            comp_addr     = '0;
            comp_cnt      = '0;
          end
        end
      end
      ACTIVE: begin
        if (bus.end_of_capture_i || bus.disarm_i) begin
          // Terminating pulse: report whatever landed, never hand over.
          comp          = 1'b1;
          comp_flags[0] = full_hit;
          comp_flags[1] = bus.end_of_capture_i;
          comp_flags[2] = bus.disarm_i;
          comp_cnt      = cnt_inc;
          cnt_n         = '0;
          state_n       = IDLE;
        end else if (full_hit) begin
          comp          = 1'b1;
          comp_flags[0] = 1'b1;
          comp_cnt      = eff_bs;
          cnt_n         = '0;
          if (!empty) begin
            pop        = 1'b1;
            dma_addr_n = mem[rd_ptr];
          end else begin
            comp_flags[3] = 1'b1;
            state_n       = IDLE;
          end
        end else if (bus.data_valid_i) begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    // Pushes into a full queue survive only when a pop frees the slot.
    push_ok = bus.addr_wr_i && (!full || pop);
    drop    = bus.addr_wr_i && !push_ok;
    if (comp) begin
      comp_flags[4] = ovf || drop;
      comp_flags[5] = irq && !bus.irq_ack_i;
    end
  end

  // Queue storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_base] <= bus.addr_i;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      rd_ptr <= (flush_now ? '0 : rd_ptr) + PW'(pop);
      wr_ptr <= wr_base + PW'(push_ok);
      level  <= (flush_now ? '0 : level) + LW'(push_ok) - LW'(pop);
    end
  end

  // Capture state, active address and word counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      dma_addr <= '0;
      cnt      <= '0;
      blk      <= '0;
    end else begin
      state    <= state_n;
      dma_addr <= dma_addr_n;
      cnt      <= cnt_n;
      blk      <= blk_n;
    end
  end

  // IRQ record and sticky overflow; a completion beats a same-cycle ack.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irq       <= 1'b0;
      irq_addr  <= '0;
      irq_count <= '0;
      irq_flags <= '0;
      ovf       <= 1'b0;
    end else begin
      if (comp) begin
        irq       <= 1'b1;
        irq_addr  <= comp_addr;
        irq_count <= comp_cnt;
        irq_flags <= comp_flags;
        ovf       <= 1'b0;
      end else begin
        if (bus.irq_ack_i) irq <= 1'b0;
        if (drop)          ovf <= 1'b1;
      end
    end
  end

  assign bus.dma_addr_o    = dma_addr;
  assign bus.dma_active_o  = (state == ACTIVE);
  assign bus.queue_level_o = level;
  assign bus.irq_o         = irq;
  assign bus.irq_addr_o    = irq_addr;
  assign bus.irq_count_o   = irq_count;
  assign bus.irq_flags_o   = irq_flags;
endmodule

// File: tb/tb_pcap_dma_buf_ctrl.sv
// Directed bench for pcap_dma_buf_ctrl: each task drives one scenario and
// compares against hand-computed values.
module tb_pcap_dma_buf_ctrl;
  logic clk = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   failures = 0;

  pcap_dma_buf_ctrl_if #(.ADDR_DEPTH(32), .AW(32), .CNT_W(16)) bus ();

  pcap_dma_buf_ctrl #(.ADDR_DEPTH(32), .AW(32), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle past the edge before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr_wr_i = 0; bus.addr_i = '0; bus.addr_flush_i = 0;
    bus.arm_i = 0; bus.disarm_i = 0; bus.end_of_capture_i = 0;
    bus.data_valid_i = 0; bus.irq_ack_i = 0;
  endtask

  task automatic push(input logic [31:0] a);
    bus.addr_wr_i = 1; bus.addr_i = a;
    tick();
    bus.addr_wr_i = 0;
  endtask

  task automatic ack();
    bus.irq_ack_i = 1;
    tick();
    bus.irq_ack_i = 0;
  endtask

  task automatic arm(input logic [15:0] bs);
    bus.blocksize_i = bs; bus.arm_i = 1;
    tick();
    bus.arm_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1;
    tick(); tick();
    checks++;
    if ({bus.irq_o, bus.dma_active_o, bus.queue_level_o, bus.dma_addr_o,
         bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o} !== '0) begin
      $display("FAIL reset_outputs got irq=%b act=%b lvl=%0d addr=%h flags=%h want all 0",
               bus.irq_o, bus.dma_active_o, bus.queue_level_o, bus.dma_addr_o, bus.irq_flags_o);
      failures++;
    end
    reset_i = 0;
    tick();
  endtask

  task automatic test_basic_fill();
    push(32'h1000); push(32'h2000);
    checks++;
    if (bus.queue_level_o !== 6'd2) begin
      $display("FAIL fill_level got %0d want 2", bus.queue_level_o); failures++;
    end
    arm(16'd4);
    checks++;
    if ({bus.dma_active_o, bus.dma_addr_o, bus.queue_level_o} !== {1'b1, 32'h1000, 6'd1}) begin
      $display("FAIL fill_arm got act=%b addr=%h lvl=%0d want 1/1000/1",
               bus.dma_active_o, bus.dma_addr_o, bus.queue_level_o); failures++;
    end
    bus.data_valid_i = 1;
    repeat (3) tick();
    checks++;
    if (bus.irq_o !== 1'b0) begin
      $display("FAIL fill_no_early_irq got %b want 0", bus.irq_o); failures++;
    end
    tick();
    bus.data_valid_i = 0;
    checks++;
    if ({bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_addr_o, bus.queue_level_o}
        !== {1'b1, 32'h1000, 16'd4, 8'h01, 32'h2000, 6'd0}) begin
      $display("FAIL fill_irq1 got irq=%b addr=%h cnt=%0d flags=%h dma=%h lvl=%0d want 1/1000/4/01/2000/0",
               bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_addr_o, bus.queue_level_o);
      failures++;
    end
    ack();
    checks++;
    if (bus.irq_o !== 1'b0) begin
      $display("FAIL fill_ack got %b want 0", bus.irq_o); failures++;
    end
    bus.data_valid_i = 1;
    repeat (4) tick();
    bus.data_valid_i = 0;
    checks++;
    if ({bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o}
        !== {1'b1, 32'h2000, 16'd4, 8'h09, 1'b0}) begin
      $display("FAIL fill_irq2 got irq=%b addr=%h cnt=%0d flags=%h act=%b want 1/2000/4/09/0",
               bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o);
      failures++;
    end
  endtask

  task automatic test_partial_eoc();
    ack();
    push(32'h1000);
    arm(16'd100);
    bus.data_valid_i = 1;
    repeat (36) tick();
    bus.end_of_capture_i = 1;
    tick();
    bus.data_valid_i = 0; bus.end_of_capture_i = 0;
    checks++;
    if ({bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o}
        !== {1'b1, 32'h1000, 16'd37, 8'h02, 1'b0}) begin
      $display("FAIL partial_eoc got irq=%b addr=%h cnt=%0d flags=%h act=%b want 1/1000/37/02/0",
               bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o);
      failures++;
    end
  endtask

  task automatic test_underrun();
    ack();
    arm(16'd4);
    checks++;
    if ({bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o}
        !== {1'b1, 32'h0, 16'd0, 8'h08, 1'b0}) begin
      $display("FAIL underrun got irq=%b addr=%h cnt=%0d flags=%h act=%b want 1/0/0/08/0",
               bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o);
      failures++;
    end
  endtask

  task automatic test_overflow();
    ack();
    for (int i = 0; i < 33; i++) push(32'hA000 + 32'(i) * 32'h100);
    checks++;
    if (bus.queue_level_o !== 6'd32) begin
      $display("FAIL ovf_level got %0d want 32", bus.queue_level_o); failures++;
    end
    arm(16'd1);
    bus.data_valid_i = 1;
    tick();
    bus.data_valid_i = 0;
    checks++;
    if ({bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_addr_o, bus.queue_level_o}
        !== {32'hA000, 16'd1, 8'h11, 32'hA100, 6'd30}) begin
      $display("FAIL ovf_flag got addr=%h cnt=%0d flags=%h dma=%h lvl=%0d want A000/1/11/A100/30",
               bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_addr_o, bus.queue_level_o);
      failures++;
    end
    ack();
    bus.disarm_i = 1;
    tick();
    bus.disarm_i = 0;
    checks++;
    if ({bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o}
        !== {32'hA100, 16'd0, 8'h04, 1'b0}) begin
      $display("FAIL ovf_cleared got addr=%h cnt=%0d flags=%h act=%b want A100/0/04/0",
               bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o);
      failures++;
    end
    bus.addr_flush_i = 1;
    tick();
    bus.addr_flush_i = 0;
    checks++;
    if (bus.queue_level_o !== 6'd0) begin
      $display("FAIL flush_level got %0d want 0", bus.queue_level_o); failures++;
    end
  endtask

  task automatic test_back_to_back();
    ack();
    push(32'hC000); push(32'hC100); push(32'hC200);
    arm(16'd1);
    bus.data_valid_i = 1;
    tick();
    checks++;
    if ({bus.irq_addr_o, bus.irq_flags_o, bus.dma_addr_o} !== {32'hC000, 8'h01, 32'hC100}) begin
      $display("FAIL b2b_first got addr=%h flags=%h dma=%h want C000/01/C100",
               bus.irq_addr_o, bus.irq_flags_o, bus.dma_addr_o); failures++;
    end
    tick();
    checks++;
    if ({bus.irq_addr_o, bus.irq_flags_o, bus.dma_addr_o} !== {32'hC100, 8'h21, 32'hC200}) begin
      $display("FAIL b2b_second got addr=%h flags=%h dma=%h want C100/21/C200",
               bus.irq_addr_o, bus.irq_flags_o, bus.dma_addr_o); failures++;
    end
    tick();
    bus.data_valid_i = 0;
    checks++;
    if ({bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o}
        !== {1'b1, 32'hC200, 16'd1, 8'h29, 1'b0}) begin
      $display("FAIL irq_overrun got irq=%b addr=%h cnt=%0d flags=%h act=%b want 1/C200/1/29/0",
               bus.irq_o, bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.dma_active_o);
      failures++;
    end
  endtask

  task automatic test_simultaneous();
    ack();
    push(32'hD000); push(32'hD100);
    arm(16'd2);
    bus.data_valid_i = 1;
    tick();
    bus.end_of_capture_i = 1; bus.disarm_i = 1;
    tick();
    bus.data_valid_i = 0; bus.end_of_capture_i = 0; bus.disarm_i = 0;
    checks++;
    if ({bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.queue_level_o, bus.dma_active_o}
        !== {32'hD000, 16'd2, 8'h07, 6'd1, 1'b0}) begin
      $display("FAIL simultaneous got addr=%h cnt=%0d flags=%h lvl=%0d act=%b want D000/2/07/1/0",
               bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o, bus.queue_level_o, bus.dma_active_o);
      failures++;
    end
  endtask

  task automatic test_ack_collision();
    // irq_o is still high here; flush then arm+ack on an empty queue.
    bus.addr_flush_i = 1;
    tick();
    bus.addr_flush_i = 0;
    bus.irq_ack_i = 1; bus.arm_i = 1; bus.blocksize_i = 16'd4;
    tick();
    bus.irq_ack_i = 0; bus.arm_i = 0;
    checks++;
    if ({bus.irq_o, bus.irq_flags_o, bus.queue_level_o} !== {1'b1, 8'h08, 6'd0}) begin
      $display("FAIL ack_collision got irq=%b flags=%h lvl=%0d want 1/08/0",
               bus.irq_o, bus.irq_flags_o, bus.queue_level_o); failures++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) push(32'hE000 + 32'(i) * 32'h10);
    arm(16'd10);
    bus.data_valid_i = 1;
    tick(); tick();
    bus.data_valid_i = 0;
    checks++;
    if ({bus.dma_active_o, bus.queue_level_o} !== {1'b1, 6'd5}) begin
      $display("FAIL mid_pre got act=%b lvl=%0d want 1/5", bus.dma_active_o, bus.queue_level_o);
      failures++;
    end
    reset_i = 1;
    tick();
    reset_i = 0;
    checks++;
    if ({bus.irq_o, bus.dma_active_o, bus.queue_level_o, bus.dma_addr_o,
         bus.irq_addr_o, bus.irq_count_o, bus.irq_flags_o} !== '0) begin
      $display("FAIL reset_mid got irq=%b act=%b lvl=%0d addr=%h flags=%h want all 0",
               bus.irq_o, bus.dma_active_o, bus.queue_level_o, bus.dma_addr_o, bus.irq_flags_o);
      failures++;
    end
  endtask

  initial begin
    idle_inputs();
    bus.blocksize_i = '0;
    reset_i = 1;
    test_reset();
    test_basic_fill();
    test_partial_eoc();
    test_underrun();
    test_overflow();
    test_back_to_back();
    test_simultaneous();
    test_ack_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcap_dma_buf_ctrl.md
# pcap_dma_buf_ctrl

Parametrised DMA buffer controller for the position-capture (PCAP) path on the carrier FPGA. It generalises the single-buffer scheme to a host-filled queue of up to ADDR_DEPTH buffer addresses. It counts captured words into the active buffer and hands over to the next address when the block fills. It reports each completed buffer through a held IRQ status record (sample count and flags) that the host must acknowledge.

## Interface
- ADDR_DEPTH, 32: depth of the buffer-address queue; power of two, 2..256.
- AW, 32: DMA address width.
- CNT_W, 16: sample-count width; also the blocksize width.
- clk_i  in  1  system clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- addr_wr_i  in  1  push addr_i into the queue.
- addr_i  in  AW  buffer base address.
- addr_flush_i  in  1  empty the queue; honoured in IDLE only.
- arm_i  in  1  start-capture pulse.
- disarm_i  in  1  abort-capture pulse.
- end_of_capture_i  in  1  capture-finished pulse.
- blocksize_i  in  CNT_W  words per buffer; latched at arm.
- data_valid_i  in  1  one captured word is written to the active buffer.
- irq_ack_i  in  1  host has read the status record.
- dma_addr_o  out  AW  active buffer address.
- dma_active_o  out  1  capture in progress; dma_addr_o is valid.
- queue_level_o  out  clog2(ADDR_DEPTH+1)  number of queued addresses.
- irq_o  out  1  completion pending; level signal.
- irq_addr_o  out  AW  address of the completed buffer.
- irq_count_o  out  CNT_W  words written to the completed buffer.
- irq_flags_o  out  8  completion flags.

## Operation
- Flag bits:
  - [0] buffer full.
  - [1] end of capture.
  - [2] disarmed.
  - [3] address underrun (queue empty when an address is needed).
  - [4] queue overflow (sticky; a push was dropped since the last completion).
  - [5] IRQ overrun (a completion occurred while irq_o was high).
  - [7:6] always 0.
- States: IDLE, ACTIVE.
- IDLE + arm_i:
  - Queue non-empty: pop the head into dma_addr_o, latch blocksize_i, clear the word count, go to ACTIVE.
  - Queue empty: emit a completion with flags bit3, addr 0 and count 0; stay in IDLE.
- arm_i in ACTIVE is ignored.
- ACTIVE: each data_valid_i increments the count.
- Block full (data_valid_i with count+1 == blocksize): emit a completion with flag0 and count = blocksize, then pop the next address and reset the count.
  - Queue empty at that point: add flag3 and go to IDLE.
- A latched blocksize of 0 behaves as 1.
- end_of_capture_i in ACTIVE: emit a completion with flag1. The count includes a same-cycle data_valid_i. Go to IDLE.
- disarm_i in ACTIVE: same as end_of_capture_i but with flag2.
  - Both pulses in the same cycle: flags 1|2.
  - Either pulse coinciding with block full: flag0 is also set, and there is no pop.
- end_of_capture_i and disarm_i in IDLE are ignored.
- Queue push:
  - Accepted in any state when not full.
  - When full, accepted only if a pop happens in the same cycle; otherwise dropped and sticky flag4 is set.
  - Flag4 is reported in, and cleared by, the next completion.
- Completion:
  - Loads irq_addr_o, irq_count_o and irq_flags_o, and sets irq_o.
  - If irq_o is already high, the new record overwrites the old one with flag5 set.
- irq_ack_i clears irq_o. A completion in the same cycle as irq_ack_i wins: irq_o stays high and flag5 is not set.
- addr_flush_i outside IDLE is ignored.

## Timing
- Reset values:
  - All outputs 0; dma_addr_o = 0.
  - Queue empty, state IDLE, sticky flag clear.
  - A reset mid-capture emits no completion.
- arm_i at cycle N → dma_active_o and dma_addr_o valid at N+1; queue_level_o decremented at N+1.
- Completion event at cycle N → irq_o and the record valid at N+1.
- Block-full handover: the new dma_addr_o is valid at N+1, the same cycle as the IRQ. data_valid_i at N+1 counts toward the new buffer.
- addr_wr_i at N → queue_level_o updates at N+1. A pushed address can be popped at N+1 at the earliest.
- Queue read is registered with no bubble: back-to-back block-full events on consecutive cycles (blocksize 1) hand out consecutive addresses every cycle.
- irq_ack_i at N → irq_o low at N+1.

## Test plan
- Basic fill:
  - Stimulus: push 0x1000 and 0x2000, blocksize 4, arm, 8 data_valid.
  - Response: IRQ {0x1000, 4, 0x01}; ack; IRQ {0x2000, 4, 0x09}; then IDLE with dma_active_o low.
- Partial end of capture:
  - Stimulus: push 0x1000, blocksize 100, arm, 37 valids, end_of_capture_i on the 37th.
  - Response: IRQ {0x1000, 37, 0x02}.
- Underrun and overflow:
  - Stimulus: arm with an empty queue.
  - Response: IRQ flags 0x08, count 0.
  - Stimulus: push 33 addresses with ADDR_DEPTH 32.
  - Response: level 32; the next completion carries flag4.
- IRQ overrun:
  - Stimulus: blocksize 1, 3 queued addresses, 3 consecutive valids, no ack.
  - Response: final record is the third address with flags 0x21 (the last completion also carries flag3 only if the queue is empty, i.e. 0x29 here).
- Simultaneous events:
  - Stimulus: disarm_i and end_of_capture_i together with a block-full valid.
  - Response: flags 0x07, no pop, level unchanged.
- Reset mid-capture:
  - Stimulus: reset_i during ACTIVE with 5 queued addresses.
  - Response: next cycle all outputs 0, level 0, no IRQ.
